// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin owner of a shared multi-way mux select.
// Issues a registered one-hot grant, drives the mux S lines with the
// owner's index, and bounds how long one owner may keep the mux while
// other requesters are waiting.
module rr_mux_arbiter #(
  parameter int SEL_W    = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2**SEL_W-1:0]   req,
  output logic [2**SEL_W-1:0]   gnt,
  output logic [SEL_W-1:0]      sel,
  output logic                  busy
);

  localparam int NUM_REQ = 2**SEL_W;
  // Hold counter must represent 0..MAX_HOLD; keep at least one bit when unlimited.
  localparam int HOLD_W  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1'b1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
  localparam logic [NUM_REQ-1:0] REQ_ZERO = {NUM_REQ{1'b0}};

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t              state_r, state_s;
  logic [NUM_REQ-1:0]  gnt_r, gnt_s;
  logic [SEL_W-1:0]    sel_r, sel_s;
  logic [SEL_W-1:0]    last_r, last_s;
  logic [HOLD_W-1:0]   hold_r, hold_s;
  logic                busy_r;
  logic [NUM_REQ-1:0]  others_s;
  logic [SEL_W-1:0]    win_req_s;
  logic [SEL_W-1:0]    win_oth_s;

  // One-hot decode of a requester index.
  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = REQ_ZERO;
    v[idx] = 1'b1;
    return v;
  endfunction

  // First set bit of cand, scanning upward from (last+1) with wrap.
  // Scanning from the far end lets the nearest candidate overwrite the rest.
  function automatic logic [SEL_W-1:0] rr_search(input logic [NUM_REQ-1:0] cand,
                                                 input logic [SEL_W-1:0]   last);
    logic [SEL_W-1:0] win;
    logic [SEL_W-1:0] idx;
    win = last;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = last + SEL_W'(i);
      win = cand[idx] ? idx : win;
    end
    return win;
  endfunction

  assign others_s  = req & ~onehot(sel_r);
  assign win_req_s = rr_search(req, last_r);
  assign win_oth_s = rr_search(others_s, last_r);

  // Next-state and next-output decision for the grant FSM.
  always_comb begin
    state_s = state_r;
    gnt_s   = gnt_r;
    sel_s   = sel_r;
    last_s  = last_r;
    hold_s  = hold_r;
    case (state_r)
      IDLE: begin
        if (req != REQ_ZERO) begin
          state_s = GRANT;
          gnt_s   = onehot(win_req_s);
          sel_s   = win_req_s;
          last_s  = win_req_s;
          hold_s  = HOLD_ONE;
        end else begin
          state_s = IDLE;
        end
      end
      GRANT: begin
        if (!req[sel_r]) begin
          // Owner released: hand off without a bubble, or fall idle.
          if (others_s != REQ_ZERO) begin
            gnt_s  = onehot(win_oth_s);
            sel_s  = win_oth_s;
            last_s = win_oth_s;
            hold_s = HOLD_ONE;
          end else begin
            state_s = IDLE;
            gnt_s   = REQ_ZERO;
            hold_s  = HOLD_ZERO;
          end
        end else if ((MAX_HOLD != 0) && (hold_r == HOLD_MAX) && (others_s != REQ_ZERO)) begin
          // Owner used its full slot while others wait: force the handoff.
          gnt_s  = onehot(win_oth_s);
          sel_s  = win_oth_s;
          last_s = win_oth_s;
          hold_s = HOLD_ONE;
        end else if (hold_r < HOLD_MAX) begin
          hold_s = hold_r + HOLD_ONE;
        end else begin
          hold_s = hold_r;
        end
      end
      default: begin
        state_s = IDLE;
        gnt_s   = REQ_ZERO;
        hold_s  = HOLD_ZERO;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      gnt_r   <= REQ_ZERO;
      sel_r   <= {SEL_W{1'b0}};
      last_r  <= {SEL_W{1'b1}};
      hold_r  <= HOLD_ZERO;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      gnt_r   <= gnt_s;
      sel_r   <= sel_s;
      last_r  <= last_s;
      hold_r  <= hold_s;
      busy_r  <= |gnt_s;
    end
  end

  assign gnt  = gnt_r;
  assign sel  = sel_r;
  assign busy = busy_r;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: directed scenarios followed by randomized request
// traffic, every cycle compared against a queue-free behavioural model
// that tracks owner / last winner / slot length as plain integers.
module tb_rr_mux_arbiter;

  localparam int SEL_W    = 4;
  localparam int MAX_HOLD = 8;
  localparam int N        = 16;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic [15:0] gnt;
  logic [3:0]  sel;
  logic        busy;

  int checks = 0;
  int fails  = 0;

  // Reference model state
  int m_owner;   // -1 when idle
  int m_sel;
  int m_last;
  int m_hold;

  rr_mux_arbiter #(.SEL_W(SEL_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .gnt  (gnt),
    .sel  (sel),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Nearest requester after 'from' going upward with wrap, -1 if none.
  function automatic int rr_pick(input logic [15:0] cand, input int from);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (from + k) % N;
      if (cand[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_win(input int w);
    m_owner = w;
    m_sel   = w;
    m_last  = w;
    m_hold  = 1;
  endtask

  task automatic model_step(input logic [15:0] r, input logic rs);
    logic [15:0] oth;
    if (rs) begin
      m_owner = -1; m_sel = 0; m_last = N - 1; m_hold = 0;
    end else if (m_owner < 0) begin
      if (r != 16'h0000) model_win(rr_pick(r, m_last));
    end else begin
      oth = r;
      oth[m_owner] = 1'b0;
      if (!r[m_owner]) begin
        if (oth != 16'h0000) model_win(rr_pick(oth, m_last));
        else begin m_owner = -1; m_hold = 0; end
      end else if (MAX_HOLD != 0 && m_hold == MAX_HOLD && oth != 16'h0000) begin
        model_win(rr_pick(oth, m_last));
      end else if (m_hold < MAX_HOLD) begin
        m_hold = m_hold + 1;
      end
    end
  endtask

  function automatic logic [15:0] exp_gnt();
    logic [15:0] v;
    v = 16'h0000;
    if (m_owner >= 0) v[m_owner] = 1'b1;
    return v;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drive one cycle, advance the model at the edge, compare just after it.
  task automatic tick(input logic [15:0] r, input logic rs);
    req = r;
    rst = rs;
    @(posedge clk);
    model_step(r, rs);
    #1;
    check("model_gnt", gnt, exp_gnt());
    check("model_sel", {12'h000, sel}, 16'(m_sel));
    check("model_busy", {15'h0000, busy}, {15'h0000, (m_owner >= 0)});
    @(negedge clk);
  endtask

  logic [15:0] rq;
  logic        rs;
  logic [15:0] e;

  initial begin
    req = 16'h0000;
    rst = 1'b1;
    m_owner = -1; m_sel = 0; m_last = N - 1; m_hold = 0;
    @(negedge clk);

    // Reset with every requester asserted
    tick(16'hFFFF, 1'b1);
    check("rst_gnt", gnt, 16'h0000);
    tick(16'hFFFF, 1'b1);
    check("rst_sel", {12'h000, sel}, 16'h0000);
    check("rst_busy", {15'h0000, busy}, 16'h0000);
    tick(16'hFFFF, 1'b0);
    check("rel_gnt", gnt, 16'h0001);
    check("rel_busy", {15'h0000, busy}, 16'h0001);

    // Timeout rotation among 0, 1, 4
    tick(16'h0013, 1'b1);
    for (int k = 0; k < 25; k++) begin
      tick(16'h0013, 1'b0);
      e = (k < 8) ? 16'h0001 : (k < 16) ? 16'h0002 : (k < 24) ? 16'h0010 : 16'h0001;
      check("rot_gnt", gnt, e);
    end

    // Lone requester is never preempted
    for (int k = 0; k < 20; k++) begin
      tick(16'h8000, 1'b0);
      check("solo_gnt", gnt, 16'h8000);
      check("solo_sel", {12'h000, sel}, 16'h000F);
    end

    // Direct handoff from owner 3 to 5
    tick(16'h0000, 1'b0);
    tick(16'h0008, 1'b0);
    check("own3_gnt", gnt, 16'h0008);
    for (int k = 0; k < 3; k++) tick(16'h0028, 1'b0);
    check("own3_hold", gnt, 16'h0008);
    tick(16'h0020, 1'b0);
    check("hand_gnt", gnt, 16'h0020);
    check("hand_sel", {12'h000, sel}, 16'h0005);
    check("hand_busy", {15'h0000, busy}, 16'h0001);

    // Wrap-around from last = 14
    tick(16'h0000, 1'b0);
    tick(16'h4000, 1'b0);
    tick(16'h0000, 1'b0);
    check("idle_sel", {12'h000, sel}, 16'h000E);
    check("idle_busy", {15'h0000, busy}, 16'h0000);
    tick(16'h8001, 1'b0);
    check("wrap_first", gnt, 16'h8000);
    tick(16'h0001, 1'b0);
    check("wrap_next", gnt, 16'h0001);

    // Reset while owner 7 holds
    tick(16'h0000, 1'b0);
    tick(16'h0080, 1'b0);
    check("own7_gnt", gnt, 16'h0080);
    tick(16'h0080, 1'b1);
    check("mid_rst_gnt", gnt, 16'h0000);
    check("mid_rst_sel", {12'h000, sel}, 16'h0000);
    tick(16'h0080, 1'b0);
    check("post_rst_gnt", gnt, 16'h0080);

    // Randomized traffic against the model
    rq = 16'h0000;
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 9))
        0: rq = 16'($urandom) & 16'($urandom);
        1: rq = 16'h0001 << $urandom_range(0, 15);
        2: rq = 16'hFFFF;
        3: rq = rq & ~exp_gnt();
        4: rq = rq | (16'h0001 << $urandom_range(0, 15));
        5: rq = 16'h0000;
        default: rq = rq;
      endcase
      rs = ($urandom_range(0, 99) == 0);
      tick(rq, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin arbiter that shares one N-bit multi-way mux (16-way at the default width) among up to 2**SEL_W requesters. It owns the mux select lines and issues a registered one-hot grant. A requester keeps the grant for as long as it holds its request, up to a bounded hold time. It sits in front of the shared read/result bus mux and drives that mux's S input directly.

## Interface
- SEL_W, 4: select width; NUM_REQ = 2**SEL_W requesters (derived, not overridable)
- MAX_HOLD, 8: maximum consecutive grant cycles while others wait; 0 = unlimited
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester request level; bit i = requester i
- gnt  out  NUM_REQ  registered one-hot grant; all-zero when idle
- sel  out  SEL_W  index of granted requester, drives mux S; holds last value when idle
- busy  out  1  registered, equals |gnt

## Operation
- Internal state:
  - IDLE (gnt == 0) or GRANT (owner = sel).
  - last[SEL_W-1:0]: index of the most recent winner.
  - hold_cnt: counts the owner's grant cycles, width ceil(log2(MAX_HOLD+1)).
- Winner search: scan for the first set bit of the candidate vector, starting at index (last+1) mod NUM_REQ and wrapping upward through NUM_REQ-1 to 0.
- IDLE:
  - If req != 0: winner = search(req). Next state GRANT, gnt = one-hot(winner), sel = winner, last = winner, hold_cnt = 1.
  - Otherwise stay IDLE.
- GRANT, owner o:
  - **Release.** req[o] == 0. Candidates = req with bit o cleared. If any candidate exists, hand off directly with no idle bubble; winner loads as in IDLE. Otherwise go to IDLE: gnt = 0, sel keeps o, hold_cnt = 0.
  - **Timeout.** req[o] == 1, MAX_HOLD != 0, hold_cnt == MAX_HOLD, and another request is pending. Force a handoff to search(req with bit o cleared). The owner loses the grant even though it is still requesting; it may win again only in its round-robin turn.
  - **Continue.** All other cases: keep the grant. hold_cnt increments and saturates at MAX_HOLD.
- Fairness rule: with all NUM_REQ requesting continuously, each requester receives exactly MAX_HOLD consecutive cycles per rotation, in ascending index order with wrap.
- Single requester: never preempted. The counter saturates and the grant is held indefinitely.
- Reset values: gnt = 0, sel = 0, busy = 0, hold_cnt = 0, last = NUM_REQ-1 (so the first search starts at index 0).
- Reset mid-grant: gnt, busy and sel clear at that edge. req is ignored while rst = 1.
- gnt is always one-hot or zero. sel is always the index of the set gnt bit whenever busy = 1.

## Timing
- All outputs are flops. No combinational path from req to any output.
- Grant latency: req rising in cycle t, sampled at edge t+1, gives gnt/sel/busy valid in cycle t+1.
- Release latency: owner deasserts req in cycle t; at edge t+1 gnt moves to the next winner or to 0.
- The mux output is valid for the owner in every cycle where gnt[o] = 1, since sel changes only at the same edge as gnt.
- Timeout: the owner holds for exactly MAX_HOLD cycles, then gnt moves at the next edge.
- Simultaneous owner release and new requests at one edge: handoff happens at that edge. The owner is excluded even if its request is asserted again at that edge.
- Requests arriving mid-grant wait. They are never dropped while held high.

## Test plan
- **Reset:** rst = 1 for 2 cycles with req = 16'hFFFF -> gnt = 0, sel = 0, busy = 0 throughout. Deassert rst -> next edge gnt = 16'h0001, sel = 0, busy = 1.
- **Timeout rotation:** req = 16'h0013 held constant, MAX_HOLD = 8 -> gnt = 16'h0001 for 8 cycles, then 16'h0002 for 8, then 16'h0010 for 8, then back to 16'h0001. No idle cycles.
- **No preemption:** req = 16'h8000 alone for 20 cycles -> gnt = 16'h8000, sel = 15 for all cycles after the first edge. The owner is never preempted.
- **Direct handoff:** owner 3 holds, req[5] high; drop req[3] -> next edge gnt = 16'h0020, sel = 5. busy stays 1 with no zero cycle.
- **Wrap-around:** last = 14 and req = 16'h8001 asserted from IDLE -> gnt = 16'h8000 first. After it releases -> gnt = 16'h0001.
- **Reset mid-grant:** owner 7 granted, rst pulsed 1 cycle -> gnt = 0, sel = 0 at that edge. With req = 16'h0080 still high, gnt = 16'h0080 one edge after rst falls.
